tri_raster: RTL and testbench
=============================

# tri_raster

Parametrised triangle rasteriser for the framebuffer path. Accepts one triangle per valid/ready handshake from the command FIFO and evaluates three signed edge functions over the triangle's screen-clipped bounding box, one pixel per cycle. It emits framebuffer writes with back-pressure, supports optional back-face culling, and reports per-triangle completion. It is the generalised successor to the fixed 640x480, 6-bit-colour, no-stall rasteriser.

## Interface
- XW, 10: vertex x coordinate width (unsigned)
- YW, 10: vertex y coordinate width (unsigned)
- SCREEN_W, 640: framebuffer width in pixels
- SCREEN_H, 480: framebuffer height in pixels
- CW, 6: colour width
- CULL, 0: 0 = draw both windings; 1 = draw only positive-area triangles
- AW, $clog2(SCREEN_W*SCREEN_H): pixel address width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- tri_valid  in  1  triangle word valid
- tri_ready  out  1  block can accept a triangle; high only in IDLE
- tri_data  in  3*(XW+YW)+CW  packed {v0,v1,v2,color}; each vertex is {x[XW-1:0], y[YW-1:0]}
- pix_wen  out  1  pixel write request
- pix_addr  out  AW  y*SCREEN_W + x
- pix_data  out  CW  triangle colour
- pix_ready  in  1  framebuffer accepts the write this cycle
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when a triangle is fully retired
- tri_count  out  16  number of retired triangles, wraps at 65535 -> 0

## Operation
- States: IDLE, SETUP, SCAN.
- IDLE: tri_ready=1. On tri_valid&&tri_ready, latch vertices and colour, then go to SETUP.
- Edge function for edge (a,b) at point p: E = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
  - Edges are e0=(v0,v1), e1=(v1,v2), e2=(v2,v0).
  - E is signed, XW+YW+3 bits wide, computed with no overflow.
- SETUP (1 cycle):
  - Compute area = E of e0 at v2.
  - Compute the bounding box, clipped to [0,SCREEN_W-1] x [0,SCREEN_H-1].
  - Reject the triangle if any of these holds: area==0; CULL==1 and area<0; xmin>SCREEN_W-1; ymin>SCREEN_H-1.
  - Rejected: return to IDLE, pulse done, increment tri_count, issue no writes.
  - Otherwise set x=xmin, y=ymin and go to SCAN.
- SCAN: row-major over the inclusive clipped bbox, x fastest.
  - Covered pixel: all three E>=0, or all three E<=0 when CULL==0. Ties on edges count as covered.
  - For a covered pixel, register pix_wen=1 with pix_addr and pix_data.
  - Uncovered pixels produce no write, but still consume one cycle.
- Back-pressure: while pix_wen && !pix_ready, pix_wen, pix_addr and pix_data hold stable and the scan position does not advance.
- SCAN exits after the last bbox pixel (x==xmax, y==ymax) is evaluated and no write is pending. On exit: done pulses, tri_count increments, state returns to IDLE.
- Reset at any time, including mid-scan:
  - State goes to IDLE; the current triangle is abandoned with no done pulse.
  - pix_wen is 0 from the next edge.
  - Output reset values: tri_ready=0 while reset is high; pix_wen=0, pix_addr=0, pix_data=0, busy=0, done=0, tri_count=0.

## Timing
- Cycle 0: handshake. Cycle 1: SETUP. Cycle 2: first bbox pixel evaluated. Cycle 3: its write, if covered, is visible on pix_wen.
- Throughput is one bbox pixel per cycle with pix_ready held high. Each cycle of pix_ready low on a pending write adds one cycle.
- done asserts in the same cycle that state becomes IDLE, so tri_ready=1 from that cycle onwards. The next handshake can occur in the done cycle.
- A rejected triangle has done on cycle 2, so the minimum turnaround is 2 cycles.
- tri_data is sampled only on a handshake; changes to it at other times have no effect.

## Test plan
- Reset: hold reset 3 cycles with random inputs. Required: all outputs 0 during reset; tri_ready=1 and busy=0 on the first cycle after.
- Right triangle (0,0),(3,0),(0,3), color 0x2A, CULL=1, pix_ready=1:
  - Exactly 10 writes, in order: addr 0,1,2,3,640,641,642,1280,1281,1920, all with data 0x2A.
  - done 1 cycle after the last bbox pixel (16 scan cycles); tri_count=1.
- Winding: same triangle with v1 and v2 swapped.
  - CULL=1: 0 writes, done on cycle 2, tri_count increments.
  - CULL=0: the identical 10 writes.
- Back-pressure: repeat the right triangle with pix_ready low for 5 cycles on the first write and low on alternate cycles afterwards.
  - pix_wen, pix_addr and pix_data are stable while stalled.
  - All 10 writes arrive in the same order, with none lost or duplicated.
- Clipping: triangle (637,0),(645,0),(637,8) on a 640x480 screen.
  - 24 writes: x=637 with y 0..8, x=638 with y 0..7, x=639 with y 0..6.
  - No write has x>639.
- Degenerate and back-to-back: send (0,0),(2,2),(4,4), then the right triangle, with tri_valid held high throughout.
  - First triangle: 0 writes and a done pulse.
  - Second triangle: accepted in the done cycle of the first and draws its 10 pixels.
  - tri_count=2 at the end.

Source files
------------

// File: rtl/tri_raster.sv
// rtl/tri_raster.sv - triangle rasteriser: edge-function scan of the clipped bounding box
// One triangle per handshake; one bbox pixel per cycle with framebuffer back-pressure.
module tri_raster #(
   parameter int XW       = 10,
   parameter int YW       = 10,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int CW       = 6,
   parameter int CULL     = 0,
   parameter int AW       = $clog2(SCREEN_W*SCREEN_H)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tri_valid,
   output logic                      tri_ready,
   input  logic [3*(XW+YW)+CW-1:0]   tri_data,
   output logic                      pix_wen,
   output logic [AW-1:0]             pix_addr,
   output logic [CW-1:0]             pix_data,
   input  logic                      pix_ready,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               tri_count
);
   localparam int VW   = XW + YW;
   localparam int EW   = XW + YW + 3;
   localparam int XMAX = SCREEN_W - 1;
   localparam int YMAX = SCREEN_H - 1;

   typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
   state_t state;

   logic [XW-1:0] x0, x1, x2, x_lo, x_hi, cur_x;
   logic [YW-1:0] y0, y1, y2, y_hi, cur_y;
   logic [CW-1:0] color;
   logic          draining;

   // Operands are zero-extended to EW bits, so differences and products cannot overflow.
   function automatic logic signed [EW-1:0] edge_fn(
      input logic [XW-1:0] ax, input logic [YW-1:0] ay,
      input logic [XW-1:0] bx, input logic [YW-1:0] by,
      input logic [XW-1:0] px, input logic [YW-1:0] py);
      logic signed [EW-1:0] dx, dy, qx, qy;
      dx = $signed(EW'(bx)) - $signed(EW'(ax));
      dy = $signed(EW'(by)) - $signed(EW'(ay));
      qx = $signed(EW'(px)) - $signed(EW'(ax));
      qy = $signed(EW'(py)) - $signed(EW'(ay));
      return (dx * qy) - (dy * qx);
   endfunction

   logic signed [EW-1:0] e0, e1, e2, area;
   logic                 all_pos, all_neg, covered, reject, last_px;
   logic [XW-1:0]        bx_min, bx_max;
   logic [YW-1:0]        by_min, by_max;

   assign e0   = edge_fn(x0, y0, x1, y1, cur_x, cur_y);
   assign e1   = edge_fn(x1, y1, x2, y2, cur_x, cur_y);
   assign e2   = edge_fn(x2, y2, x0, y0, cur_x, cur_y);
   assign area = edge_fn(x0, y0, x1, y1, x2, y2);

   assign all_pos = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
   assign all_neg = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
   assign covered = all_pos || ((CULL == 0) && all_neg);
   assign last_px = (cur_x == x_hi) && (cur_y == y_hi);

   always_comb begin
      bx_min = x0;
      bx_max = x0;
      by_min = y0;
      by_max = y0;
      if (x1 < bx_min) bx_min = x1;
      if (x2 < bx_min) bx_min = x2;
      if (x1 > bx_max) bx_max = x1;
      if (x2 > bx_max) bx_max = x2;
      if (y1 < by_min) by_min = y1;
      if (y2 < by_min) by_min = y2;
      if (y1 > by_max) by_max = y1;
      if (y2 > by_max) by_max = y2;
      reject = (area == 0) || ((CULL != 0) && area[EW-1])
            || (32'(bx_min) > XMAX) || (32'(by_min) > YMAX);
   end

   assign tri_ready = !reset && (state == IDLE);
   assign busy      = !reset && (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pix_wen   <= 1'b0;
         pix_addr  <= '0;
         pix_data  <= '0;
         done      <= 1'b0;
         tri_count <= '0;
         draining  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (tri_valid) begin
                  x0    <= tri_data[CW+3*VW-1 -: XW];
                  y0    <= tri_data[CW+2*VW+YW-1 -: YW];
                  x1    <= tri_data[CW+2*VW-1 -: XW];
                  y1    <= tri_data[CW+VW+YW-1 -: YW];
                  x2    <= tri_data[CW+VW-1 -: XW];
                  y2    <= tri_data[CW+YW-1 -: YW];
                  color <= tri_data[CW-1:0];
                  state <= SETUP;
               end
            end
            SETUP: begin
               cur_x    <= bx_min;
               cur_y    <= by_min;
               x_lo     <= bx_min;
               x_hi     <= (32'(bx_max) > XMAX) ? XW'(XMAX) : bx_max;
               y_hi     <= (32'(by_max) > YMAX) ? YW'(YMAX) : by_max;
               draining <= 1'b0;
               if (reject) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  tri_count <= tri_count + 16'd1;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               // A stalled write freezes both the output and the scan position.
               if (!(pix_wen && !pix_ready)) begin
                  if (draining) begin
                     pix_wen   <= 1'b0;
                     draining  <= 1'b0;
                     state     <= IDLE;
                     done      <= 1'b1;
                     tri_count <= tri_count + 16'd1;
                  end else begin
                     pix_wen <= covered;
                     if (covered) begin
                        pix_addr <= AW'(cur_y) * AW'(SCREEN_W) + AW'(cur_x);
                        pix_data <= color;
                     end
                     if (last_px) begin
                        if (covered) begin
                           draining <= 1'b1;
                        end else begin
                           state     <= IDLE;
                           done      <= 1'b1;
                           tri_count <= tri_count + 16'd1;
                        end
                     end else if (cur_x == x_hi) begin
                        cur_x <= x_lo;
                        cur_y <= cur_y + YW'(1);
                     end else begin
                        cur_x <= cur_x + XW'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tri_raster.sv
// tb/tb_tri_raster.sv - scoreboard bench for tri_raster, CULL=0 and CULL=1 instances side by side
module tb_tri_raster;
   localparam int XW = 10, YW = 10, CW = 6, AW = 19;

   logic clk = 1'b0, reset = 1'b1, tri_valid = 1'b0, pix_ready = 1'b1;
   logic [65:0] tri_data = '0;

   logic tri_ready_0, pix_wen_0, busy_0, done_0, tri_ready_1, pix_wen_1, busy_1, done_1;
   logic [AW-1:0] pix_addr_0, pix_addr_1;
   logic [CW-1:0] pix_data_0, pix_data_1;
   logic [15:0]   tri_count_0, tri_count_1;

   tri_raster #(.CULL(0)) u_c0 (
      .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready_0),
      .tri_data(tri_data), .pix_wen(pix_wen_0), .pix_addr(pix_addr_0),
      .pix_data(pix_data_0), .pix_ready(pix_ready), .busy(busy_0), .done(done_0),
      .tri_count(tri_count_0));

   tri_raster #(.CULL(1)) u_c1 (
      .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready_1),
      .tri_data(tri_data), .pix_wen(pix_wen_1), .pix_addr(pix_addr_1),
      .pix_data(pix_data_1), .pix_ready(pix_ready), .busy(busy_1), .done(done_1),
      .tri_count(tri_count_1));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int q0[$], q1[$];
   bit mon_en = 0, bp_mode = 0, rst_rand = 0;
   int bp_stalls = 0;
   bit prev_stall[2];
   logic [AW-1:0] prev_a[2];
   logic [CW-1:0] prev_d[2];
   int rt_addr[10] = '{0, 1, 2, 3, 640, 641, 642, 1280, 1281, 1920};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [65:0] pack(input int ax, ay, bx, by, cx, cy, col);
      return {10'(ax), 10'(ay), 10'(bx), 10'(by), 10'(cx), 10'(cy), 6'(col)};
   endfunction

   task automatic expect_wr(input int id, input int addr, input int col);
      if (id == 0) q0.push_back(addr * 64 + col);
      else         q1.push_back(addr * 64 + col);
   endtask

   task automatic expect_right(input int id);
      for (int i = 0; i < 10; i++) expect_wr(id, rt_addr[i], 'h2A);
   endtask

   task automatic mon(input int id, input logic wen, input logic [AW-1:0] a, input logic [CW-1:0] d);
      int exp;
      if (prev_stall[id])
         check($sformatf("stall_hold%0d", id), {wen, a, d}, {1'b1, prev_a[id], prev_d[id]});
      if (wen && pix_ready) begin
         if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write%0d: got addr %0d expected no write", id, a);
         end else begin
            exp = (id == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("write%0d", id), {a, d}, exp[AW+CW-1:0]);
         end
      end
      prev_stall[id] = wen && !pix_ready;
      prev_a[id] = a;
      prev_d[id] = d;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, pix_wen_0, pix_addr_0, pix_data_0);
         mon(1, pix_wen_1, pix_addr_1, pix_data_1);
      end else begin
         prev_stall[0] = 0;
         prev_stall[1] = 0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rst_rand) pix_ready = 1'($urandom);
      else if (!bp_mode) pix_ready = 1'b1;
      else if (bp_stalls < 5) begin
         pix_ready = 1'b0;
         if (pix_wen_1) bp_stalls++;
      end else pix_ready = ~pix_ready;
   end

   // Returns one cycle after the handshake edge (start of SETUP).
   task automatic send(input logic [65:0] td, input bit hold);
      bit ok;
      @(posedge clk);
      #1;
      tri_data = td;
      tri_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (tri_ready_0 && tri_ready_1) ok = 1;
      end
      check("handshake", ok, 1);
      @(posedge clk);
      #1;
      if (!hold) tri_valid = 1'b0;
   endtask

   task automatic wait_done(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int c = 1; c <= 400 && (c0 == 0 || c1 == 0); c++) begin
         @(negedge clk);
         if (done_0 && c0 == 0) c0 = c;
         if (done_1 && c1 == 0) c1 = c;
      end
   endtask

   task automatic end_test(input string name, input int cnt);
      check({name, "_q0_empty"}, q0.size(), 0);
      check({name, "_q1_empty"}, q1.size(), 0);
      check({name, "_count0"}, tri_count_0, cnt);
      check({name, "_count1"}, tri_count_1, cnt);
   endtask

   initial begin
      int c0, c1;
      bit saw_done, saw_wen;

      rst_rand = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         tri_valid = 1'($urandom);
         tri_data = 66'({$urandom, $urandom, $urandom});
         @(negedge clk);
         check("rst_ctl0", {tri_ready_0, pix_wen_0, busy_0, done_0, tri_count_0}, 0);
         check("rst_pix0", {pix_addr_0, pix_data_0}, 0);
         check("rst_ctl1", {tri_ready_1, pix_wen_1, busy_1, done_1, tri_count_1}, 0);
         check("rst_pix1", {pix_addr_1, pix_data_1}, 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tri_valid = 1'b0;
      rst_rand = 0;
      pix_ready = 1'b1;
      @(negedge clk);
      check("post_rst_ready_busy", {tri_ready_0, busy_0, tri_ready_1, busy_1}, 4'b1010);
      mon_en = 1;

      expect_right(0);
      expect_right(1);
      send(pack(0, 0, 3, 0, 0, 3, 'h2A), 0);
      wait_done(c0, c1);
      check("right_done0", c0, 18);
      check("right_done1", c1, 18);
      end_test("right", 1);

      expect_right(0);
      send(pack(0, 0, 0, 3, 3, 0, 'h2A), 0);
      wait_done(c0, c1);
      check("swap_done0", c0, 18);
      check("swap_done1_culled", c1, 2);
      end_test("swap", 2);

      expect_right(0);
      expect_right(1);
      bp_stalls = 0;
      bp_mode = 1;
      send(pack(0, 0, 3, 0, 0, 3, 'h2A), 0);
      wait_done(c0, c1);
      bp_mode = 0;
      check("bp_done0", c0, 31);
      check("bp_done1", c1, 31);
      end_test("bp", 3);

      for (int y = 0; y <= 8; y++)
         for (int x = 637; x <= 639; x++)
            if ((x - 637) + y <= 8) begin
               expect_wr(0, y * 640 + x, 'h15);
               expect_wr(1, y * 640 + x, 'h15);
            end
      send(pack(637, 0, 645, 0, 637, 8, 'h15), 0);
      wait_done(c0, c1);
      check("clip_done0", c0, 29);
      check("clip_done1", c1, 29);
      end_test("clip", 4);

      mon_en = 0;
      send(pack(0, 0, 3, 0, 0, 3, 'h2A), 0);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ctl0", {pix_wen_0, busy_0, done_0, tri_count_0}, 0);
      check("midrst_ctl1", {pix_wen_1, busy_1, done_1, tri_count_1}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      saw_done = 0;
      saw_wen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_0 || done_1) saw_done = 1;
         if (pix_wen_0 || pix_wen_1) saw_wen = 1;
      end
      check("midrst_no_done", saw_done, 0);
      check("midrst_no_wen", saw_wen, 0);
      mon_en = 1;

      send(pack(0, 0, 2, 2, 4, 4, 'h11), 1);
      tri_data = pack(0, 0, 3, 0, 0, 3, 'h2A);
      expect_right(0);
      expect_right(1);
      @(negedge clk);
      @(negedge clk);
      check("degen_done_ready0", {done_0, tri_ready_0}, 2'b11);
      check("degen_done_ready1", {done_1, tri_ready_1}, 2'b11);
      @(posedge clk);
      #1;
      tri_valid = 1'b0;
      wait_done(c0, c1);
      check("b2b_done0", c0, 18);
      check("b2b_done1", c1, 18);
      end_test("b2b", 2);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
